k051937_lb_sched: RTL

Sequencer for the sprite line-buffer pair in the sprite layer data processor. It accepts per-sprite 8-pixel render jobs from the sprite list walker and requests each GFX ROM row fetch. It then steps the render write address across the line buffer and swaps the render/display buffer pair at every line boundary. Jobs that have not completed when a line ends are aborted, and the overrun is reported to the rest of the sprite pipeline.

---
 rtl/k051937_pkg.sv | 16 +
 rtl/lb_wr_addr_gen.sv | 37 +++
 rtl/k051937_lb_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/k051937_pkg.sv
// Shared types and constants for the sprite line-buffer sequencer.
package k051937_pkg;

    localparam int WR_CYCLES_DEF   = 4;
    localparam int ROM_TIMEOUT_DEF = 15;
    localparam int LB_ADDR_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_JOB,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } lb_state_t;

endpackage

// File: rtl/lb_wr_addr_gen.sv
// Render-side write address generator: loads the sprite pair address,
// steps it (wrapping mod 256) and flags the final write cycle of a job.
module lb_wr_addr_gen
    import k051937_pkg::*;
#(
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LB_ADDR_W-1:0] base,
    input  logic                 step,
    output logic [LB_ADDR_W-1:0] addr,
    output logic                 last
);

    localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // Load the job base address, then advance address and write count together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= base;
            cnt  <= '0;
        end else if (step) begin
            addr <= addr + LB_ADDR_W'(1);
            cnt  <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(WR_CYCLES - 1));

endmodule

// File: rtl/k051937_lb_sched.sv
// Sprite line-buffer sequencer: accepts 8-pixel render jobs, fetches the
// GFX ROM row, steps the write address and swaps buffers on each line.
module k051937_lb_sched
    import k051937_pkg::*;
#(
    parameter int WR_CYCLES   = WR_CYCLES_DEF,
    parameter int ROM_TIMEOUT = ROM_TIMEOUT_DEF
) (
    input  logic       clk_12M,
    input  logic       nRES,
    input  logic       new_line,
    input  logic       job_valid,
    input  logic [8:0] job_x,
    input  logic [7:0] job_pal,
    input  logic       job_hflip,
    input  logic       job_last,
    output logic       job_ready,
    output logic       rom_req,
    input  logic       rom_ack,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic       wr_phase,
    output logic [7:0] wr_pal,
    output logic       wr_hflip,
    output logic       pair,
    output logic       busy,
    output logic       overrun,
    output logic       rom_err
);

    lb_state_t state, state_next;

    logic [7:0] job_base;
    logic       last_q;
    logic       nl_q;
    logic [7:0] tmo_cnt;
    logic       accept;
    logic       tmo_hit;
    logic       addr_load;
    logic       addr_step;
    logic       wr_last;

    // State register.
    always_ff @(posedge clk_12M or negedge nRES) begin
        if (!nRES) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and outputs decoded from registered state; a line
    // boundary overrides everything else happening in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        tmo_hit    = 1'b0;
        addr_load  = 1'b0;
        addr_step  = 1'b0;
        job_ready  = (state == ST_WAIT_JOB) && !nl_q;
        rom_req    = (state == ST_FETCH);
        wr_en      = (state == ST_WRITE);
        busy       = (state != ST_IDLE) && (state != ST_DONE);
        if (new_line) begin
            state_next = ST_WAIT_JOB;
        end else begin
            case (state)
                ST_WAIT_JOB: begin
                    if (job_valid && job_ready) begin
                        accept     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rom_ack) begin
                        addr_load  = 1'b1;
                        state_next = ST_WRITE;
                    end else if (tmo_cnt == 8'(ROM_TIMEOUT - 1)) begin
                        tmo_hit    = 1'b1;
                        state_next = last_q ? ST_DONE : ST_WAIT_JOB;
                    end
                end
                ST_WRITE: begin
                    if (wr_last) begin
                        state_next = last_q ? ST_DONE : ST_WAIT_JOB;
                    end else begin
                        addr_step = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line-boundary bookkeeping: buffer swap, overrun capture, error pulse.
    always_ff @(posedge clk_12M or negedge nRES) begin
        if (!nRES) begin
            pair    <= 1'b0;
            overrun <= 1'b0;
            nl_q    <= 1'b0;
            rom_err <= 1'b0;
        end else begin
            nl_q    <= new_line;
            rom_err <= tmo_hit;
            if (new_line) begin
                pair    <= ~pair;
                overrun <= (state == ST_FETCH) || (state == ST_WRITE) ||
                           ((state == ST_WAIT_JOB) && !last_q);
            end
        end
    end

    // Job field latches, held from acceptance until the next accepted job.
    always_ff @(posedge clk_12M or negedge nRES) begin
        if (!nRES) begin
            job_base <= '0;
            wr_phase <= 1'b0;
            wr_pal   <= '0;
            wr_hflip <= 1'b0;
            last_q   <= 1'b0;
        end else if (new_line) begin
            last_q <= 1'b0;
        end else if (accept) begin
            job_base <= job_x[8:1];
            wr_phase <= job_x[0];
            wr_pal   <= job_pal;
            wr_hflip <= job_hflip;
            last_q   <= job_last;
        end
    end

    // ROM wait counter, restarted whenever a job enters FETCH.
    always_ff @(posedge clk_12M or negedge nRES) begin
        if (!nRES) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ST_FETCH) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    lb_wr_addr_gen #(
        .WR_CYCLES(WR_CYCLES)
    ) u_addr_gen (
        .clk   (clk_12M),
        .rst_n (nRES),
        .load  (addr_load),
        .base  (job_base),
        .step  (addr_step),
        .addr  (wr_addr),
        .last  (wr_last)
    );

endmodule
